cpu4_instr_sequencer: RTL and testbench
=======================================

# cpu4_instr_sequencer

Instruction sequencer driving the 4-bit accumulator CPU's instruction pins (opcode, address, data, write enable) from a 16-entry program store, and capturing the CPU's accumulator result after each instruction. It is the initiator side of the CPU instruction interface: the CPU executes whatever is on its pins, and this block decides what to present and when. Results stream out over a valid/ready port for logging or display.

## Interface
- `CPU_LAT`, default 3: cycles from instruction issue until `cpu_acc` is stable; legal range 1..15.
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `prog_we` in 1: program-store write strobe; ignored while `busy`.
- `prog_addr` in 4: program-store write address.
- `prog_word` in 12: {opcode[11:8], addr[7:4], data[3:0]}.
- `prog_len` in 5: instruction count, sampled on accepted `start`; 0 means empty; values >16 clamp to 16.
- `start` in 1: level-sampled run request.
- `busy` out 1: high from the cycle after accepted `start` through the DONE state.
- `done` out 1: one-cycle pulse at run end.
- `cpu_opcode` out 4, `cpu_addr` out 4, `cpu_data` out 4: instruction fields to the CPU.
- `cpu_we` out 1: CPU write enable.
- `cpu_acc` in 4: CPU accumulator value.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_data` out 4: captured accumulator.
- `res_pc` out 4: program index that produced `res_data`.

## Operation
- Program store: 16 x 12-bit, written when `prog_we` is high and not busy. Not cleared by `rst`; contents survive reset.
- NOP opcode 4'b1111. Also acts as HALT when fetched.
- States: IDLE, ISSUE, WAIT, EMIT, DONE.
- IDLE:
  - `cpu_opcode`=1111, `cpu_addr`=0, `cpu_data`=0, `cpu_we`=0.
  - `start` with clamped len≠0: pc←0, latch len, go to ISSUE.
  - `start` with len=0: go to DONE.
- ISSUE (1 cycle):
  - Fetch word[pc] and drive its fields.
  - `cpu_we`=1 iff opcode==4'b0010 (STORE).
  - If opcode==1111 (HALT): go to DONE with no result.
  - Otherwise: wait counter←CPU_LAT−1, go to WAIT.
- WAIT:
  - Fields and `cpu_we` held exactly as in ISSUE.
  - Counter decrements each cycle. In the cycle it reads 0, `cpu_acc` is captured into `res_data`, `res_pc`←pc, and the state moves to EMIT.
- EMIT:
  - `res_valid`=1. `res_data` and `res_pc` are stable; CPU fields are still held, `cpu_we`=0.
  - On `res_valid & res_ready`: if pc==len−1, go to DONE; else pc←pc+1 and go to ISSUE.
- DONE: `done`=1 for one cycle, fields return to NOP, go to IDLE.
- `start` while busy: ignored, except when the loop feature is compiled in (see Configuration).
- Reset values:
  - `busy`=0, `done`=0, `res_valid`=0, `res_data`=0, `res_pc`=0.
  - `cpu_opcode`=1111, `cpu_addr`=0, `cpu_data`=0, `cpu_we`=0.
  - State=IDLE, pc=0.
- Reset mid-run: next cycle is IDLE with all outputs at reset values. Any pending result is dropped.

## Timing
- `start` sampled at edge E0. ISSUE occupies cycle 1. WAIT occupies cycles 2..CPU_LAT+1. EMIT begins at cycle CPU_LAT+2.
- With `res_ready` held high, each instruction costs CPU_LAT+2 cycles.
- After the last handshake, DONE occupies the next cycle and IDLE follows.
- `res_valid` never deasserts without a handshake, except on `rst`.
- `res_data` and `res_pc` are registered and change only on capture.

## Configuration
- `SEQ_LOOP_EN` defined:
  - After the last instruction's handshake, pc←0 and the state returns to ISSUE; the program repeats indefinitely.
  - `start` high while busy sets a stop flag. The run then ends at the next EMIT handshake: DONE, `done` pulse, IDLE.
  - HALT still ends the run immediately.
- `SEQ_LOOP_EN` undefined: single pass only; `start` while busy ignored.

## Test plan
- Reset: assert `rst` 2 cycles → `cpu_opcode`=1111, `busy`=0, `res_valid`=0, `done`=0.
- Basic run, 2 instructions:
  - Setup: word0={0000,0011,0101}, word1={0110,0000,1010}, len=2, CPU_LAT=3, `res_ready`=1, `cpu_acc`=7.
  - Cycle 1: `cpu_opcode`=0000, `cpu_addr`=3, `cpu_data`=5.
  - Cycle 5: `res_valid`, `res_data`=7, `res_pc`=0.
  - Cycle 6: `cpu_opcode`=0110.
  - Cycle 10: `res_pc`=1.
  - Cycle 11: `done`.
- Backpressure: hold `res_ready` low 4 cycles in the first EMIT → `res_valid`, `res_data`, `res_pc` and CPU fields unchanged; second ISSUE is delayed by exactly 4 cycles.
- STORE and HALT:
  - Program {0010,0100,0000},{1111,x,x},{0000,..}, len=3 → `cpu_we`=1 in ISSUE+WAIT of pc0 only.
  - One result (`res_pc`=0), then `done` with no second `res_valid`.
- Empty run: len=0 → `done` pulse in the cycle after `start`, no `res_valid`.
- Reset mid-run, then restart: `rst` asserted during WAIT → IDLE next cycle. Rerun without reloading gives identical results because the program store is retained.
- With `SEQ_LOOP_EN`: len=2 → `res_pc` sequence 0,1,0,1… Pulse `start` during pc1 WAIT → `done` after pc1 handshake.

Source files
------------

// File: rtl/cpu4_instr_sequencer_if.sv
// Instruction/result bus between the sequencer and the 4-bit accumulator CPU.
// master: sequencer side (drives CPU instruction pins and result stream).
// slave : CPU/consumer side (drives accumulator value and result ready).
//   cpu_opcode/cpu_addr/cpu_data/cpu_we : instruction presented to the CPU
//   cpu_acc                             : CPU accumulator readback
//   res_valid/res_ready/res_data/res_pc : captured result stream
interface cpu4_instr_sequencer_if;
  logic [3:0] cpu_opcode;
  logic [3:0] cpu_addr;
  logic [3:0] cpu_data;
  logic       cpu_we;
  logic [3:0] cpu_acc;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic [3:0] res_pc;

  modport master (
    output cpu_opcode, cpu_addr, cpu_data, cpu_we,
    output res_valid, res_data, res_pc,
    input  cpu_acc, res_ready
  );

  modport slave (
    input  cpu_opcode, cpu_addr, cpu_data, cpu_we,
    input  res_valid, res_data, res_pc,
    output cpu_acc, res_ready
  );
endinterface

// File: rtl/cpu4_instr_sequencer.sv
// Instruction sequencer for the 4-bit accumulator CPU: steps through a
// 16-entry program store, presents each instruction on the CPU pins, waits
// CPU_LAT cycles, captures the accumulator and streams it out with its pc.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   prog_we/prog_addr/prog_word   : program-store write (ignored while busy)
//   prog_len                      : instruction count, sampled on start
//   start                         : run request (level sampled)
//   busy, done                    : run in progress / one-cycle end pulse
//   bus (master)                  : CPU instruction pins and result stream
// Optional feature: define SEQ_LOOP_EN to repeat the program until a
// start-while-busy stop request or a HALT.
module cpu4_instr_sequencer #(
  parameter int unsigned CPU_LAT = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          prog_we,
  input  logic [3:0]                    prog_addr,
  input  logic [11:0]                   prog_word,
  input  logic [4:0]                    prog_len,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  cpu4_instr_sequencer_if.master        bus
);

  localparam int unsigned PC_W  = 4;
  localparam int unsigned LEN_W = 5;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned WRD_W = 12;
  localparam logic [3:0]  OP_NOP   = 4'hF;
  localparam logic [3:0]  OP_STORE = 4'h2;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_EMIT, S_DONE} state_t;

  state_t             state;
  logic [PC_W-1:0]    pc;
  logic [LEN_W-1:0]   len;
  logic [CNT_W-1:0]   cnt;
  logic [WRD_W-1:0]   mem [16];
`ifdef SEQ_LOOP_EN
  logic               stop;
`endif

  logic [LEN_W-1:0]   len_clamped_c;
  logic               last_c;
  logic [PC_W-1:0]    fetch_addr_c;
  logic [WRD_W-1:0]   fetch_word_c;

  // Program store: no reset, contents survive rst
  always_ff @(posedge clk) begin
    if (prog_we && !busy) mem[prog_addr] <= prog_word;
  end

  assign len_clamped_c = (prog_len > 5'd16) ? 5'd16 : prog_len;
  assign last_c        = ({1'b0, pc} == (len - 5'd1));
  // Next instruction: pc+1 while mid-program, otherwise entry 0 (start or loop)
  assign fetch_addr_c  = (state == S_EMIT && !last_c) ? (pc + 4'd1) : 4'd0;
  assign fetch_word_c  = mem[fetch_addr_c];

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      pc             <= '0;
      len            <= '0;
      cnt            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      bus.res_valid  <= 1'b0;
      bus.res_data   <= '0;
      bus.res_pc     <= '0;
      bus.cpu_opcode <= OP_NOP;
      bus.cpu_addr   <= '0;
      bus.cpu_data   <= '0;
      bus.cpu_we     <= 1'b0;
`ifdef SEQ_LOOP_EN
      stop           <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SEQ_LOOP_EN
      if (busy && start) stop <= 1'b1;
`endif
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len_clamped_c != '0) begin
              pc    <= '0;
              len   <= len_clamped_c;
              state <= S_ISSUE;
              {bus.cpu_opcode, bus.cpu_addr, bus.cpu_data} <= fetch_word_c;
              bus.cpu_we <= (fetch_word_c[11:8] == OP_STORE);
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (bus.cpu_opcode == OP_NOP) begin
            // HALT: end the run without producing a result
            state          <= S_DONE;
            done           <= 1'b1;
            bus.cpu_opcode <= OP_NOP;
            bus.cpu_addr   <= '0;
            bus.cpu_data   <= '0;
            bus.cpu_we     <= 1'b0;
          end else begin
            cnt   <= CNT_W'(CPU_LAT - 1);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            bus.res_data  <= bus.cpu_acc;
            bus.res_pc    <= pc;
            bus.res_valid <= 1'b1;
            bus.cpu_we    <= 1'b0;
            state         <= S_EMIT;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_EMIT: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
`ifdef SEQ_LOOP_EN
            if (stop) begin
`else
            if (last_c) begin
`endif
              state          <= S_DONE;
              done           <= 1'b1;
              bus.cpu_opcode <= OP_NOP;
              bus.cpu_addr   <= '0;
              bus.cpu_data   <= '0;
              bus.cpu_we     <= 1'b0;
            end else begin
              // fetch_addr_c wraps to 0 after the last entry (loop build only)
              pc    <= fetch_addr_c;
              state <= S_ISSUE;
              {bus.cpu_opcode, bus.cpu_addr, bus.cpu_data} <= fetch_word_c;
              bus.cpu_we <= (fetch_word_c[11:8] == OP_STORE);
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
`ifdef SEQ_LOOP_EN
          stop  <= 1'b0;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu4_instr_sequencer.sv
// Self-checking bench for cpu4_instr_sequencer (single-pass build).
// A schedule model derives, per cycle, the expected pins/results from the
// program, the ready pattern and the accumulator values driven each cycle.
module tb_cpu4_instr_sequencer;
  localparam int unsigned LAT  = 3;
  localparam int          MAXC = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [11:0] prog_word;
  logic [4:0]  prog_len;
  logic        start;
  logic        busy;
  logic        done;

  cpu4_instr_sequencer_if bus ();

  cpu4_instr_sequencer #(.CPU_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_word (prog_word),
    .prog_len  (prog_len),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [11:0] prog_m [16];
  logic [3:0]  last_data = '0;
  logic [3:0]  last_pc   = '0;

  logic        ready_at  [MAXC];
  logic [3:0]  acc_at    [MAXC];
  logic        exp_busy  [MAXC];
  logic        exp_done  [MAXC];
  logic        exp_valid [MAXC];
  logic        exp_we    [MAXC];
  logic [11:0] exp_fld   [MAXC];
  logic [3:0]  exp_rd    [MAXC];
  logic [3:0]  exp_rp    [MAXC];

  task automatic chk(input string tag, input int c, input logic [11:0] got, input logic [11:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, c, got, exp);
    end
  endtask

  task automatic check_cycle(input int c);
    chk("busy",     c, 12'(busy),          12'(exp_busy[c]));
    chk("done",     c, 12'(done),          12'(exp_done[c]));
    chk("fields",   c, {bus.cpu_opcode, bus.cpu_addr, bus.cpu_data}, exp_fld[c]);
    chk("cpu_we",   c, 12'(bus.cpu_we),    12'(exp_we[c]));
    chk("res_valid",c, 12'(bus.res_valid), 12'(exp_valid[c]));
    chk("res_data", c, 12'(bus.res_data),  12'(exp_rd[c]));
    chk("res_pc",   c, 12'(bus.res_pc),    12'(exp_rp[c]));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"},   0, 12'(busy),          12'h000);
    chk({tag, "_done"},   0, 12'(done),          12'h000);
    chk({tag, "_fields"}, 0, {bus.cpu_opcode, bus.cpu_addr, bus.cpu_data}, 12'hF00);
    chk({tag, "_we"},     0, 12'(bus.cpu_we),    12'h000);
    chk({tag, "_valid"},  0, 12'(bus.res_valid), 12'h000);
    chk({tag, "_rdata"},  0, 12'(bus.res_data),  12'h000);
    chk({tag, "_rpc"},    0, 12'(bus.res_pc),    12'h000);
  endtask

  // Write all 16 entries of prog_m into the store; ends at a negedge, idle inputs
  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      prog_we   = 1'b1;
      prog_addr = 4'(i);
      prog_word = prog_m[i];
      @(negedge clk);
    end
    prog_we = 1'b0;
  endtask

  // ready_mode: 0 always ready, 1 random, 2 four stalled cycles in first EMIT
  // acc_fixed: <0 random accumulator each cycle; rst_at: <0 no mid-run reset
  task automatic run(input logic [4:0] len_in, input int ready_mode, input int acc_fixed, input int rst_at);
    int          len;
    int          t;
    int          h;
    int          done_c;
    logic [11:0] w;
    logic [3:0]  new_data;
    logic [3:0]  new_pc;

    for (int c = 0; c < MAXC; c++) begin
      case (ready_mode)
        0:       ready_at[c] = 1'b1;
        1:       ready_at[c] = (c >= 300) ? 1'b1 : 1'($urandom_range(0, 1));
        default: ready_at[c] = !(c >= int'(LAT) + 2 && c < int'(LAT) + 6);
      endcase
      acc_at[c]    = (acc_fixed >= 0) ? 4'(acc_fixed) : 4'($urandom_range(0, 15));
      exp_busy[c]  = 1'b0;
      exp_done[c]  = 1'b0;
      exp_valid[c] = 1'b0;
      exp_we[c]    = 1'b0;
      exp_fld[c]   = 12'hF00;
      exp_rd[c]    = last_data;
      exp_rp[c]    = last_pc;
    end

    // Schedule: instruction i issues at t, holds for LAT cycles, then emits
    // until the first ready cycle h; the next instruction issues at h+1.
    len      = (len_in > 5'd16) ? 16 : int'(len_in);
    new_data = last_data;
    new_pc   = last_pc;
    done_c   = 1;
    t        = 1;
    for (int i = 0; i < len; i++) begin
      w = prog_m[i];
      exp_fld[t] = w;
      if (w[11:8] == 4'hF) begin
        done_c = t + 1;
        break;
      end
      for (int c = t; c <= t + int'(LAT); c++) begin
        exp_fld[c] = w;
        exp_we[c]  = (w[11:8] == 4'h2);
      end
      h = t + int'(LAT) + 1;
      while (!ready_at[h]) h++;
      for (int c = t + int'(LAT) + 1; c <= h; c++) begin
        exp_fld[c]   = w;
        exp_valid[c] = 1'b1;
      end
      new_data = acc_at[t + int'(LAT)];
      new_pc   = 4'(i);
      for (int c = t + int'(LAT) + 1; c < MAXC; c++) begin
        exp_rd[c] = new_data;
        exp_rp[c] = new_pc;
      end
      t      = h + 1;
      done_c = h + 1;
    end
    for (int c = 1; c <= done_c; c++) exp_busy[c] = 1'b1;
    exp_done[done_c] = 1'b1;

    for (int c = 0; c <= done_c + 2; c++) begin
      check_cycle(c);
      start         = (c == 0);
      prog_len      = len_in;
      bus.res_ready = ready_at[c];
      bus.cpu_acc   = acc_at[c];
      // Writes while busy must not disturb the store
      prog_we       = (c >= 1 && c <= done_c) ? 1'($urandom_range(0, 1)) : 1'b0;
      prog_addr     = 4'($urandom_range(0, 15));
      prog_word     = 12'($urandom_range(0, 4095));
      if (c == rst_at) begin
        rst     = 1'b1;
        start   = 1'b0;
        prog_we = 1'b0;
        @(negedge clk);
        check_reset("midrun_rst");
        rst       = 1'b0;
        last_data = '0;
        last_pc   = '0;
        return;
      end
      @(negedge clk);
    end
    last_data = new_data;
    last_pc   = new_pc;
  endtask

  initial begin
    rst           = 1'b1;
    prog_we       = 1'b0;
    prog_addr     = '0;
    prog_word     = '0;
    prog_len      = '0;
    start         = 1'b0;
    bus.res_ready = 1'b0;
    bus.cpu_acc   = '0;
    @(negedge clk);
    @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset("post_reset");

    // Basic two-instruction run, constant accumulator 7
    for (int i = 0; i < 16; i++) prog_m[i] = 12'($urandom_range(0, 4095));
    prog_m[0] = 12'h035;
    prog_m[1] = 12'h60A;
    load_prog();
    run(5'd2, 0, 7, -1);

    // Backpressure in the first EMIT
    run(5'd2, 2, -1, -1);

    // STORE then HALT
    prog_m[0] = 12'h240;
    prog_m[1] = 12'hF5A;
    prog_m[2] = 12'h012;
    load_prog();
    run(5'd3, 0, -1, -1);

    // Empty program
    run(5'd0, 1, -1, -1);

    // Random programs, lengths (including >16) and backpressure
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 16; i++) prog_m[i] = 12'($urandom_range(0, 4095));
      load_prog();
      run(5'($urandom_range(0, 31)), 1, -1, -1);
    end

    // Full-length program without HALT, clamped length
    for (int i = 0; i < 16; i++) prog_m[i] = {4'($urandom_range(0, 14)), 8'($urandom_range(0, 255))};
    load_prog();
    run(5'd31, 1, -1, -1);

    // Reset during WAIT of pc0, then rerun twice without reloading
    run(5'd4, 0, -1, 3);
    run(5'd4, 0, 5, -1);
    run(5'd4, 1, 5, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
